// File: rtl/ble_rx_demod_sync.sv
// BLE RX GFSK demodulator: I/Q cross-product discriminator, integrate-and-dump
// slicer, access-address correlator with error tolerance and payload streaming.
module ble_rx_demod_sync #(
    parameter int          IQ_W         = 4,
    parameter int          OSR          = 8,
    parameter logic [31:0] AA           = 32'h8E89BED6,
    parameter int          AA_MAX_ERR   = 1,
    parameter int          PAYLOAD_BITS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [IQ_W-1:0]  i_in,
    input  logic signed [IQ_W-1:0]  q_in,
    input  logic [$clog2(OSR)-1:0]  sym_phase,
    output logic                    bit_valid,
    output logic                    bit_data,
    output logic                    pkt_detect,
    output logic                    pkt_active,
    output logic                    pkt_done,
    output logic [2:0]              det_count,
    output logic                    demod_sign
);
    localparam int SC_W  = $clog2(OSR);
    localparam int D_W   = 2 * IQ_W + 1;
    localparam int ACC_W = D_W + SC_W;
    localparam int BC_W  = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic {SEARCH, PAYLOAD} state_t;

    logic signed [IQ_W-1:0]  r_i_prev, r_q_prev;
    logic signed [D_W-1:0]   r_d;
    logic signed [D_W-1:0]   w_ip, w_qp, w_ic, w_qc, w_d;
    logic signed [ACC_W-1:0] r_acc, w_sum;
    logic [SC_W-1:0]         r_sc;
    logic                    r_v1, r_dump1, r_sign;
    logic                    r_bit_v, r_bit, w_dec;

    state_t                  r_state, w_state_n;
    logic [31:0]             r_sr, w_sr_n, w_sr_shift;
    logic [BC_W-1:0]         r_bc, w_bc_n;
    logic [2:0]              r_det, w_det_n;
    logic                    r_detect, w_detect_n;
    logic                    r_bv, w_bv_n, r_bd, w_bd_n;
    logic                    r_last, w_last_n, r_done;
    logic                    w_take;
    int                      w_err;

    assign w_ip = {{(D_W-IQ_W){r_i_prev[IQ_W-1]}}, r_i_prev};
    assign w_qp = {{(D_W-IQ_W){r_q_prev[IQ_W-1]}}, r_q_prev};
    assign w_ic = {{(D_W-IQ_W){i_in[IQ_W-1]}}, i_in};
    assign w_qc = {{(D_W-IQ_W){q_in[IQ_W-1]}}, q_in};
    assign w_d  = w_ip * w_qc - w_qp * w_ic;

    assign w_sum = r_acc + {{SC_W{r_d[D_W-1]}}, r_d};
    assign w_dec = !w_sum[ACC_W-1] && (w_sum != '0);

    // Every stage holds while en is low, so pending samples and decisions survive a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_prev <= '0;
            r_q_prev <= '0;
            r_d      <= '0;
            r_sign   <= 1'b0;
            r_sc     <= '0;
            r_v1     <= 1'b0;
            r_dump1  <= 1'b0;
            r_acc    <= '0;
            r_bit_v  <= 1'b0;
            r_bit    <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                r_d      <= w_d;
                r_sign   <= !w_d[D_W-1] && (w_d != '0);
                r_i_prev <= i_in;
                r_q_prev <= q_in;
                r_sc     <= r_sc + SC_W'(1);
                r_dump1  <= (r_sc == sym_phase);
                r_v1     <= 1'b1;
            end else begin
                r_v1     <= 1'b0;
            end
            if (r_v1) begin
                r_acc   <= r_dump1 ? '0 : w_sum;
                r_bit   <= w_dec;
                r_bit_v <= r_dump1;
            end else begin
                r_bit_v <= 1'b0;
            end
        end
    end

    assign w_take     = en && r_bit_v;
    assign w_sr_shift = {r_bit, r_sr[31:1]};
    assign w_err      = $countones(w_sr_shift ^ AA);

    always_comb begin
        w_state_n  = r_state;
        w_sr_n     = r_sr;
        w_bc_n     = r_bc;
        w_det_n    = r_det;
        w_detect_n = 1'b0;
        w_bv_n     = 1'b0;
        w_bd_n     = r_bd;
        w_last_n   = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_take) begin
                    w_sr_n = w_sr_shift;
                    if (w_err <= AA_MAX_ERR) begin
                        w_detect_n = 1'b1;
                        if (r_det != 3'd7) w_det_n = r_det + 3'd1;
                        w_sr_n    = '0;
                        w_bc_n    = '0;
                        w_state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_take) begin
                    w_bv_n = 1'b1;
                    w_bd_n = r_bit;
                    if (r_bc == BC_W'(PAYLOAD_BITS - 1)) begin
                        w_last_n  = 1'b1;
                        w_sr_n    = '0;
                        w_bc_n    = '0;
                        w_state_n = SEARCH;
                    end else begin
                        w_bc_n = r_bc + BC_W'(1);
                    end
                end
            end
            default: w_state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEARCH;
            r_sr     <= '0;
            r_bc     <= '0;
            r_det    <= '0;
            r_detect <= 1'b0;
            r_bv     <= 1'b0;
            r_bd     <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_sr     <= w_sr_n;
            r_bc     <= w_bc_n;
            r_det    <= w_det_n;
            r_detect <= w_detect_n;
            r_bv     <= w_bv_n;
            r_bd     <= w_bd_n;
            r_last   <= w_last_n;
            r_done   <= r_last;
        end
    end

    assign bit_valid  = r_bv;
    assign bit_data   = r_bd;
    assign pkt_detect = r_detect;
    assign pkt_active = (r_state == PAYLOAD);
    assign pkt_done   = r_done;
    assign det_count  = r_det;
    assign demod_sign = r_sign;

endmodule

// File: tb/tb_ble_rx_demod_sync.sv
// Directed self-checking bench for ble_rx_demod_sync: tones, AA detection with
// error tolerance, mid-packet reset, enable freeze and detection-counter saturation.
module tb_ble_rx_demod_sync;
    localparam logic [31:0] AA      = 32'h8E89BED6;
    localparam logic [63:0] PAYLOAD = 64'hA5A5A5A5A5A5A5A5;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0;
    logic [3:0] i_in = '0, q_in = '0;
    logic [2:0] sym_phase = 3'd7;
    logic       bit_valid, bit_data, pkt_detect, pkt_active, pkt_done, demod_sign;
    logic [2:0] det_count;
    logic [8:0] w_outs;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, phase = 0;
    int n_detect = 0, n_done = 0, n_bits = 0;
    int detect_cyc = 0, done_cyc = 0, bv_cyc = 0;
    logic [63:0] rx_sr = '0;

    ble_rx_demod_sync #(
        .IQ_W(4), .OSR(8), .AA(32'h8E89BED6), .AA_MAX_ERR(1), .PAYLOAD_BITS(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .sym_phase(sym_phase),
        .bit_valid(bit_valid), .bit_data(bit_data), .pkt_detect(pkt_detect),
        .pkt_active(pkt_active), .pkt_done(pkt_done), .det_count(det_count),
        .demod_sign(demod_sign)
    );

    assign w_outs = {bit_valid, bit_data, pkt_detect, pkt_active, pkt_done, det_count, demod_sign};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pkt_detect) begin n_detect++; detect_cyc = cyc; end
        if (pkt_done)   begin n_done++;   done_cyc = cyc;   end
        if (bit_valid)  begin n_bits++; rx_sr = {bit_data, rx_sr[63:1]}; bv_cyc = cyc; end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Constellation points at phase 0..3: (7,0),(0,7),(-7,0),(0,-7)
    task automatic send_sample(input int dir);
        @(posedge clk); #1;
        phase = (phase + dir + 4) % 4;
        case (phase)
            0: begin i_in = 4'd7;     q_in = 4'd0;     end
            1: begin i_in = 4'd0;     q_in = 4'd7;     end
            2: begin i_in = 4'b1001;  q_in = 4'd0;     end
            default: begin i_in = 4'd0; q_in = 4'b1001; end
        endcase
        in_valid = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        repeat (8) send_sample(b ? 1 : -1);
    endtask

    task automatic send_word32(input logic [31:0] w);
        for (int k = 0; k < 32; k++) send_bit(w[k]);
    endtask

    task automatic send_payload(input int lo, input int hi);
        logic [63:0] p;
        p = PAYLOAD;
        for (int k = lo; k <= hi; k++) send_bit(p[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; en = 1'b1; sym_phase = 3'd7; phase = 0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            en = 1'($urandom); in_valid = 1'($urandom);
            i_in = 4'($urandom); q_in = 4'($urandom); sym_phase = 3'($urandom);
            @(negedge clk);
            n_checks++;
            if (w_outs !== 9'd0) begin n_fail++; $display("FAIL reset_hold: outputs=%b expected 0", w_outs); end
        end
        @(posedge clk); #1;
        en = 1'b1; in_valid = 1'b0; sym_phase = 3'd7; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (w_outs !== 9'd0) begin n_fail++; $display("FAIL reset_release: outputs=%b expected 0", w_outs); end
        end
    endtask

    task automatic test_tone();
        int d0, b0;
        reset_dut();
        d0 = n_detect; b0 = n_bits;
        for (int k = 0; k < 40; k++) send_bit(1'b1);
        @(negedge clk);
        n_checks++;
        if (demod_sign !== 1'b1) begin n_fail++; $display("FAIL tone_pos_sign: demod_sign=%b expected 1", demod_sign); end
        idle(8);
        n_checks++;
        if (n_detect - d0 != 0) begin n_fail++; $display("FAIL tone_no_detect: detects=%0d expected 0", n_detect - d0); end
        n_checks++;
        if (n_bits - b0 != 0 || pkt_active !== 1'b0) begin
            n_fail++; $display("FAIL tone_no_payload: bits=%0d active=%b expected 0/0", n_bits - b0, pkt_active);
        end
        for (int k = 0; k < 4; k++) send_bit(1'b0);
        @(negedge clk);
        n_checks++;
        if (demod_sign !== 1'b0) begin n_fail++; $display("FAIL tone_neg_sign: demod_sign=%b expected 0", demod_sign); end
        idle(8);
    endtask

    task automatic test_exact_aa();
        int d0, b0, dn0, last_aa;
        reset_dut();
        d0 = n_detect; b0 = n_bits; dn0 = n_done;
        send_word32(AA);
        last_aa = cyc;
        send_payload(0, 63);
        idle(8);
        n_checks++;
        if (n_detect - d0 != 1) begin n_fail++; $display("FAIL exact_detect: detects=%0d expected 1", n_detect - d0); end
        n_checks++;
        if (detect_cyc - last_aa != 3) begin n_fail++; $display("FAIL exact_latency: latency=%0d expected 3", detect_cyc - last_aa); end
        n_checks++;
        if (n_bits - b0 != 64) begin n_fail++; $display("FAIL exact_bitcount: bits=%0d expected 64", n_bits - b0); end
        n_checks++;
        if (rx_sr !== PAYLOAD) begin n_fail++; $display("FAIL exact_payload: data=%h expected %h", rx_sr, PAYLOAD); end
        n_checks++;
        if (n_done - dn0 != 1 || done_cyc != bv_cyc + 1) begin
            n_fail++; $display("FAIL exact_done: dones=%0d at %0d expected 1 at %0d", n_done - dn0, done_cyc, bv_cyc + 1);
        end
        n_checks++;
        if (det_count !== 3'd1 || pkt_active !== 1'b0) begin
            n_fail++; $display("FAIL exact_count: det_count=%0d active=%b expected 1/0", det_count, pkt_active);
        end
    endtask

    task automatic test_error_tol();
        int d0;
        d0 = n_detect;
        send_word32(AA ^ 32'h0000_0020);
        send_payload(0, 63);
        idle(8);
        n_checks++;
        if (n_detect - d0 != 1 || det_count !== 3'd2) begin
            n_fail++; $display("FAIL err1_detect: detects=%0d det_count=%0d expected 1/2", n_detect - d0, det_count);
        end
        d0 = n_detect;
        send_word32(AA ^ 32'h0010_0020);
        idle(8);
        n_checks++;
        if (n_detect - d0 != 0 || det_count !== 3'd2 || pkt_active !== 1'b0) begin
            n_fail++; $display("FAIL err2_reject: detects=%0d det_count=%0d active=%b expected 0/2/0", n_detect - d0, det_count, pkt_active);
        end
    endtask

    task automatic test_reset_mid_packet();
        int b0, dn0, d0;
        reset_dut();
        b0 = n_bits; dn0 = n_done;
        send_word32(AA);
        send_payload(0, 9);
        idle(5);
        n_checks++;
        if (n_bits - b0 != 10 || pkt_active !== 1'b1) begin
            n_fail++; $display("FAIL midrst_prebits: bits=%0d active=%b expected 10/1", n_bits - b0, pkt_active);
        end
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (w_outs !== 9'd0) begin n_fail++; $display("FAIL midrst_outputs: outputs=%b expected 0", w_outs); end
        idle(3);
        rst_n = 1'b1;
        idle(10);
        n_checks++;
        if (n_done - dn0 != 0 || det_count !== 3'd0) begin
            n_fail++; $display("FAIL midrst_nodone: dones=%0d det_count=%0d expected 0/0", n_done - dn0, det_count);
        end
        d0 = n_detect; b0 = n_bits; dn0 = n_done;
        send_word32(AA);
        send_payload(0, 63);
        idle(8);
        n_checks++;
        if (n_detect - d0 != 1 || det_count !== 3'd1 || n_done - dn0 != 1) begin
            n_fail++; $display("FAIL midrst_resend: detects=%0d det_count=%0d dones=%0d expected 1/1/1", n_detect - d0, det_count, n_done - dn0);
        end
        n_checks++;
        if (n_bits - b0 != 64 || rx_sr !== PAYLOAD) begin
            n_fail++; $display("FAIL midrst_payload: bits=%0d data=%h expected 64/%h", n_bits - b0, rx_sr, PAYLOAD);
        end
    endtask

    task automatic test_en_freeze();
        int b0, dn0, nb;
        b0 = n_bits; dn0 = n_done;
        send_word32(AA);
        send_payload(0, 19);
        @(posedge clk); #1;
        en = 1'b0; in_valid = 1'b1; i_in = 4'($urandom); q_in = 4'($urandom);
        nb = n_bits;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 19) begin
                en = 1'b1; in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom); i_in = 4'($urandom); q_in = 4'($urandom);
            end
        end
        n_checks++;
        if (n_bits != nb) begin n_fail++; $display("FAIL en_frozen: bits during freeze=%0d expected 0", n_bits - nb); end
        send_payload(20, 63);
        idle(8);
        n_checks++;
        if (n_bits - b0 != 64 || rx_sr !== PAYLOAD) begin
            n_fail++; $display("FAIL en_payload: bits=%0d data=%h expected 64/%h", n_bits - b0, rx_sr, PAYLOAD);
        end
        n_checks++;
        if (n_done - dn0 != 1 || det_count !== 3'd2) begin
            n_fail++; $display("FAIL en_done: dones=%0d det_count=%0d expected 1/2", n_done - dn0, det_count);
        end
    endtask

    task automatic test_back_to_back();
        int d0, dn0, b0;
        reset_dut();
        d0 = n_detect; dn0 = n_done; b0 = n_bits;
        for (int p = 0; p < 9; p++) begin
            send_word32(AA);
            send_payload(0, 63);
        end
        idle(8);
        n_checks++;
        if (det_count !== 3'd7) begin n_fail++; $display("FAIL sat_count: det_count=%0d expected 7", det_count); end
        n_checks++;
        if (n_detect - d0 != 9 || n_done - dn0 != 9) begin
            n_fail++; $display("FAIL sat_pulses: detects=%0d dones=%0d expected 9/9", n_detect - d0, n_done - dn0);
        end
        n_checks++;
        if (n_bits - b0 != 576 || rx_sr !== PAYLOAD) begin
            n_fail++; $display("FAIL sat_bits: bits=%0d data=%h expected 576/%h", n_bits - b0, rx_sr, PAYLOAD);
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_exact_aa();
        test_error_tol();
        test_reset_mid_packet();
        test_en_freeze();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_rx_demod_sync.md
Name: ble_rx_demod_sync

Overview:
Parametrised successor to the current BLE RX top: an I/Q GFSK demodulator with integrate-and-dump bit slicing, access-address (AA) correlation with error tolerance, and payload bit streaming. It sits between the BPF I/Q input pins and the packet/debug status outputs of the Tiny Tapeout wrapper. I/Q width, oversampling, AA and payload length are generics rather than fixed.

Parameters:
IQ_W, 4, signed two's-complement width of I and Q samples
OSR, 8, samples per symbol (power of 2, ≥2)
AA, 32'h8E89BED6, access address; transmitted/received LSB-first
AA_MAX_ERR, 1, max Hamming distance accepted as a match (0..3)
PAYLOAD_BITS, 64, bits streamed after AA match

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  block enable; low ignores in_valid, freezes all state
in_valid  in  1  one-cycle strobe: i_in/q_in hold a new sample
i_in  in  IQ_W  I sample, signed
q_in  in  IQ_W  Q sample, signed
sym_phase  in  $clog2(OSR)  sample-counter value at which a symbol dumps
bit_valid  out  1  one-cycle strobe: bit_data valid (PAYLOAD only)
bit_data  out  1  demodulated payload bit
pkt_detect  out  1  one-cycle pulse on AA match
pkt_active  out  1  high while in PAYLOAD
pkt_done  out  1  one-cycle pulse after last payload bit
det_count  out  3  AA matches since reset, saturates at 7
demod_sign  out  1  sign of latest discriminator (1 = positive freq)

Behaviour:
- Reset (async assert, sync release): all outputs 0, state SEARCH, registers/counters 0, previous sample = (0,0).
- Stage 1, on in_valid&en: d = I_prev*Q_cur − Q_prev*I_cur, signed 2*IQ_W+1 bits; registered; demod_sign = (d>0) registered same cycle; cur becomes prev.
- Sample counter sc (log2 OSR bits) increments on each accepted sample, wraps at OSR.
- Stage 2: acc (signed, 2*IQ_W+1+log2(OSR) bits, no overflow) adds d. When the sample with sc==sym_phase is accumulated, decide bit = (acc+d > 0), acc clears to 0. A sample accepted at cycle t produces its decision at t+2.
- sym_phase change takes effect at the next compare; there is no realignment of acc.
- FSM:
  SEARCH: each decided bit shifts into 32-bit sr from MSB (sr = {bit, sr[31:1]}). If popcount(sr_next ^ AA) ≤ AA_MAX_ERR, pkt_detect=1 at t+3, det_count+=1 (saturating), sr cleared, bit counter bc=0, go PAYLOAD. The AA bits themselves never raise bit_valid.
  PAYLOAD: pkt_active=1; each decided bit gives bit_valid=1, bit_data=bit at t+3; bc increments. On the PAYLOAD_BITS-th bit, pkt_done pulses the cycle after that bit's bit_valid, then go SEARCH with sr=0.
- A decision coinciding with the SEARCH→PAYLOAD transition is processed in the new state (no bit is lost or duplicated).
- en low: no stage advances and pending pipeline values hold; pulses already scheduled still fire once. No additional pulses occur.
- rst_n asserted mid-packet: immediate return to reset values; no pkt_done is issued.
- in_valid may arrive on consecutive cycles (full throughput, 1 sample/clk).

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release: outputs remain 0 until samples arrive.
- Positive tone (IQ_W=4): repeat (7,0),(0,7),(-7,0),(0,-7), in_valid every cycle, sym_phase=7 → d=49 each sample, demod_sign=1, every decision=1, no pkt_detect (0xFFFFFFFF vs AA distance >1).
- Exact AA: modulate AA LSB-first (+rotation=1, −rotation=0, OSR samples/bit), then 64 payload bits 0xA5A5... → pkt_detect 3 cycles after the last AA-bit dump sample, then 64 bit_valid with the payload pattern, then pkt_done; det_count=1.
- Error tolerance (AA_MAX_ERR=1): AA with bit 5 flipped → detected. AA with bits 5 and 20 flipped → no pkt_detect, det_count unchanged.
- Reset mid-packet: assert rst_n after 10 payload bits → outputs 0, no pkt_done. Re-sent AA is detected normally.
- en/saturation: drop en for 20 cycles mid-payload → bit stream resumes without loss or duplicate. Send 9 valid packets → det_count holds at 7.
